// File: rtl/ramb_pkg.sv
// Shared types and geometry for the 2048 x 9 true dual-port block RAM.
// Pure declarations: no latency, no flow control.
// Backpressure: none (RAM ports are always ready).
package ramb_pkg;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int PW    = 1;
    localparam int WW    = DW + PW;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } write_mode_e;

    typedef logic [WW-1:0] word_t;

    // One port's request as sampled at the clock edge.
    typedef struct packed {
        logic          en;
        logic          we;
        logic          ssr;
        logic [AW-1:0] addr;
        word_t         wr_dat;
    } port_req_t;

    function automatic word_t pack_word(input logic par, input logic [DW-1:0] dat);
        return {par, dat};
    endfunction

endpackage

// File: rtl/ramb_port.sv
// Output register of one RAM port: SSR, read data and write-mode selection.
// Latency: one cycle from the sampled request to dout.
// Backpressure: none; en=0 simply holds the output.
module ramb_port
    import ramb_pkg::*;
#(
    parameter word_t       INIT       = '0,
    parameter word_t       SRVAL      = '0,
    parameter write_mode_e WRITE_MODE = WRITE_FIRST
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          en,
    input  logic          we,
    input  logic          ssr,
    input  logic [WW-1:0] wr_dat,
    input  logic [WW-1:0] rd_dat,
    output logic [WW-1:0] dout
);

    word_t dout_nxt;

    // rd_dat is the array contents before this edge's writes land, so
    // READ_FIRST and cross-port readers both see the old word.
    always_comb begin
        dout_nxt = dout;
        if (en) begin
            if (ssr) begin
                dout_nxt = SRVAL;
            end else if (!we) begin
                dout_nxt = rd_dat;
            end else begin
                case (WRITE_MODE)
                    WRITE_FIRST: dout_nxt = wr_dat;
                    READ_FIRST:  dout_nxt = rd_dat;
                    default:     dout_nxt = dout;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout <= INIT;
        end else begin
            dout <= dout_nxt;
        end
    end

endmodule

// File: rtl/ramb16_s9_s9.sv
// Single-clock true dual-port 2048 x (8+1) block RAM, RAMB16_S9_S9 compatible.
// Latency: one cycle read on both ports.
// Backpressure: none; same-address double write keeps port A's data.
module ramb16_s9_s9
    import ramb_pkg::*;
#(
    parameter word_t       INIT_A       = 9'h000,
    parameter word_t       INIT_B       = 9'h000,
    parameter word_t       SRVAL_A      = 9'h000,
    parameter word_t       SRVAL_B      = 9'h000,
    parameter write_mode_e WRITE_MODE_A = WRITE_FIRST,
    parameter write_mode_e WRITE_MODE_B = WRITE_FIRST
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  DIA,
    input  logic        DIPA,
    input  logic [10:0] ADDRA,
    input  logic        ENA,
    input  logic        WEA,
    input  logic        SSRA,
    output logic [7:0]  DOA,
    output logic        DOPA,
    input  logic [7:0]  DIB,
    input  logic        DIPB,
    input  logic [10:0] ADDRB,
    input  logic        ENB,
    input  logic        WEB,
    input  logic        SSRB,
    output logic [7:0]  DOB,
    output logic        DOPB
);

    port_req_t req_a;
    port_req_t req_b;
    word_t     rd_a;
    word_t     rd_b;
    word_t     dout_a;
    word_t     dout_b;
    logic      wr_a;
    logic      wr_b;
    logic      addr_match;

    // Power-up contents are zero; reset never touches the array.
    word_t mem [DEPTH] = '{default: '0};

    assign req_a = '{en: ENA, we: WEA, ssr: SSRA, addr: ADDRA, wr_dat: pack_word(DIPA, DIA)};
    assign req_b = '{en: ENB, we: WEB, ssr: SSRB, addr: ADDRB, wr_dat: pack_word(DIPB, DIB)};

    assign addr_match = (req_a.addr == req_b.addr);

    // Port A wins a same-address write collision; writes are blocked in reset.
    assign wr_a = reset_n & req_a.en & req_a.we;
    assign wr_b = reset_n & req_b.en & req_b.we & ~(wr_a & addr_match);

    always_ff @(posedge clock) begin
        if (wr_a) begin
            mem[req_a.addr] <= req_a.wr_dat;
        end
        if (wr_b) begin
            mem[req_b.addr] <= req_b.wr_dat;
        end
    end

    assign rd_a = mem[req_a.addr];
    assign rd_b = mem[req_b.addr];

    ramb_port #(
        .INIT       (INIT_A),
        .SRVAL      (SRVAL_A),
        .WRITE_MODE (WRITE_MODE_A)
    ) u_port_a (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (req_a.en),
        .we      (req_a.we),
        .ssr     (req_a.ssr),
        .wr_dat  (req_a.wr_dat),
        .rd_dat  (rd_a),
        .dout    (dout_a)
    );

    ramb_port #(
        .INIT       (INIT_B),
        .SRVAL      (SRVAL_B),
        .WRITE_MODE (WRITE_MODE_B)
    ) u_port_b (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (req_b.en),
        .we      (req_b.we),
        .ssr     (req_b.ssr),
        .wr_dat  (req_b.wr_dat),
        .rd_dat  (rd_b),
        .dout    (dout_b)
    );

    assign {DOPA, DOA} = dout_a;
    assign {DOPB, DOB} = dout_b;

endmodule

// File: tb/tb_ramb16_s9_s9.sv
// Directed bench for ramb16_s9_s9: three instances share stimulus and differ
// only in port A write mode (WRITE_FIRST / READ_FIRST / NO_CHANGE).
module tb_ramb16_s9_s9;
    import ramb_pkg::*;

    logic        clock = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset_n;
    logic [7:0]  DIA, DIB;
    logic        DIPA, DIPB;
    logic [10:0] ADDRA, ADDRB;
    logic        ENA, WEA, SSRA, ENB, WEB, SSRB;

    logic [7:0]  doa [3];
    logic        dopa [3];
    logic [7:0]  dob [3];
    logic        dopb [3];

    int nvec = 0;
    int nmis = 0;

    always #5 clock = clk_en ? ~clock : 1'b0;

    ramb16_s9_s9 #(.INIT_A(9'h1AB), .INIT_B(9'h000), .SRVAL_A(9'h1C3), .SRVAL_B(9'h0FF),
                   .WRITE_MODE_A(WRITE_FIRST), .WRITE_MODE_B(WRITE_FIRST)) u_wf (
        .clock(clock), .reset_n(reset_n),
        .DIA(DIA), .DIPA(DIPA), .ADDRA(ADDRA), .ENA(ENA), .WEA(WEA), .SSRA(SSRA),
        .DOA(doa[0]), .DOPA(dopa[0]),
        .DIB(DIB), .DIPB(DIPB), .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
        .DOB(dob[0]), .DOPB(dopb[0]));

    ramb16_s9_s9 #(.INIT_A(9'h1AB), .INIT_B(9'h000), .SRVAL_A(9'h1C3), .SRVAL_B(9'h0FF),
                   .WRITE_MODE_A(READ_FIRST), .WRITE_MODE_B(WRITE_FIRST)) u_rf (
        .clock(clock), .reset_n(reset_n),
        .DIA(DIA), .DIPA(DIPA), .ADDRA(ADDRA), .ENA(ENA), .WEA(WEA), .SSRA(SSRA),
        .DOA(doa[1]), .DOPA(dopa[1]),
        .DIB(DIB), .DIPB(DIPB), .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
        .DOB(dob[1]), .DOPB(dopb[1]));

    ramb16_s9_s9 #(.INIT_A(9'h1AB), .INIT_B(9'h000), .SRVAL_A(9'h1C3), .SRVAL_B(9'h0FF),
                   .WRITE_MODE_A(NO_CHANGE), .WRITE_MODE_B(WRITE_FIRST)) u_nc (
        .clock(clock), .reset_n(reset_n),
        .DIA(DIA), .DIPA(DIPA), .ADDRA(ADDRA), .ENA(ENA), .WEA(WEA), .SSRA(SSRA),
        .DOA(doa[2]), .DOPA(dopa[2]),
        .DIB(DIB), .DIPB(DIPB), .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
        .DOB(dob[2]), .DOPB(dopb[2]));

    typedef struct {
        string       name;
        logic        ena, wea, ssra;
        logic [10:0] addra;
        logic [8:0]  dia;
        logic        enb, web, ssrb;
        logic [10:0] addrb;
        logic [8:0]  dib;
        logic        chk_b;
        logic [8:0]  exp_b;
        logic [8:0]  exp_a0, exp_a1, exp_a2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name,
                                logic ena, logic wea, logic ssra, logic [10:0] addra, logic [8:0] dia,
                                logic enb, logic web, logic ssrb, logic [10:0] addrb, logic [8:0] dib,
                                logic chk_b, logic [8:0] exp_b,
                                logic [8:0] exp_a0, logic [8:0] exp_a1, logic [8:0] exp_a2);
        vec_t v;
        v.name = name;
        v.ena = ena; v.wea = wea; v.ssra = ssra; v.addra = addra; v.dia = dia;
        v.enb = enb; v.web = web; v.ssrb = ssrb; v.addrb = addrb; v.dib = dib;
        v.chk_b = chk_b; v.exp_b = exp_b;
        v.exp_a0 = exp_a0; v.exp_a1 = exp_a1; v.exp_a2 = exp_a2;
        return v;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 9'h%03h, expected 9'h%03h", name, act, exp);
        end
    endtask

    task automatic check_a_all(input string name, input logic [8:0] e0, input logic [8:0] e1,
                               input logic [8:0] e2);
        check({name, ".a_wf"}, {dopa[0], doa[0]}, e0);
        check({name, ".a_rf"}, {dopa[1], doa[1]}, e1);
        check({name, ".a_nc"}, {dopa[2], doa[2]}, e2);
    endtask

    task automatic drive_idle();
        ENA = 1'b0; WEA = 1'b0; SSRA = 1'b0; ADDRA = '0; {DIPA, DIA} = '0;
        ENB = 1'b0; WEB = 1'b0; SSRB = 1'b0; ADDRB = '0; {DIPB, DIB} = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        ENA = v.ena; WEA = v.wea; SSRA = v.ssra; ADDRA = v.addra; {DIPA, DIA} = v.dia;
        ENB = v.enb; WEB = v.web; SSRB = v.ssrb; ADDRB = v.addrb; {DIPB, DIB} = v.dib;
        @(posedge clock);
        #1;
        check_a_all(v.name, v.exp_a0, v.exp_a1, v.exp_a2);
        if (v.chk_b) check({v.name, ".b"}, {dopb[0], dob[0]}, v.exp_b);
    endtask

    initial begin
        reset_n = 1'b1;
        drive_idle();

        // Asynchronous reset with the clock stopped.
        #2 reset_n = 1'b0;
        #1;
        check_a_all("rst_async", 9'h1AB, 9'h1AB, 9'h1AB);
        check("rst_async.b", {dopb[0], dob[0]}, 9'h000);

        // Writes attempted while in reset must not land.
        clk_en = 1'b1;
        @(negedge clock);
        ENA = 1'b1; WEA = 1'b1; ADDRA = 11'h005; {DIPA, DIA} = 9'h1FF;
        repeat (2) @(posedge clock);
        #1;
        check_a_all("rst_hold", 9'h1AB, 9'h1AB, 9'h1AB);
        @(negedge clock);
        reset_n = 1'b1;
        WEA = 1'b0;
        @(posedge clock);
        #1;
        check_a_all("rst_nowrite", 9'h000, 9'h000, 9'h000);
        check("rst_nowrite.b", {dopb[0], dob[0]}, 9'h000);

        //             name          A:en we ssr addr    di       B:en we ssr addr    di      chkB expB     WF      RF      NC
        vecs.push_back(mk("xport_wr",  1,1,0, 11'h010, 9'h15A,   0,0,0, 11'h000, 9'h000,  1, 9'h000, 9'h15A, 9'h000, 9'h000));
        vecs.push_back(mk("xport_rd",  0,0,0, 11'h000, 9'h000,   1,0,0, 11'h010, 9'h000,  1, 9'h15A, 9'h15A, 9'h000, 9'h000));
        vecs.push_back(mk("mem3_init", 1,1,0, 11'h003, 9'h011,   0,0,0, 11'h000, 9'h000,  1, 9'h15A, 9'h011, 9'h000, 9'h000));
        vecs.push_back(mk("rd10",      1,0,0, 11'h010, 9'h000,   0,0,0, 11'h000, 9'h000,  0, 9'h000, 9'h15A, 9'h15A, 9'h15A));
        vecs.push_back(mk("wmode",     1,1,0, 11'h003, 9'h022,   0,0,0, 11'h000, 9'h000,  0, 9'h000, 9'h022, 9'h011, 9'h15A));
        vecs.push_back(mk("rd3",       1,0,0, 11'h003, 9'h000,   0,0,0, 11'h000, 9'h000,  0, 9'h000, 9'h022, 9'h022, 9'h022));
        vecs.push_back(mk("enb_off",   0,0,0, 11'h000, 9'h000,   0,1,0, 11'h003, 9'h0EE,  1, 9'h15A, 9'h022, 9'h022, 9'h022));
        vecs.push_back(mk("enb_off_rd",1,0,0, 11'h003, 9'h000,   0,0,0, 11'h000, 9'h000,  1, 9'h15A, 9'h022, 9'h022, 9'h022));
        vecs.push_back(mk("ssrb",      0,0,0, 11'h000, 9'h000,   1,1,1, 11'h003, 9'h033,  1, 9'h0FF, 9'h022, 9'h022, 9'h022));
        vecs.push_back(mk("ssrb_wr",   1,0,0, 11'h003, 9'h000,   0,0,0, 11'h000, 9'h000,  1, 9'h0FF, 9'h033, 9'h033, 9'h033));
        vecs.push_back(mk("ssra",      1,0,1, 11'h003, 9'h000,   0,0,0, 11'h000, 9'h000,  1, 9'h0FF, 9'h1C3, 9'h1C3, 9'h1C3));
        vecs.push_back(mk("coll_ww",   1,1,0, 11'h007, 9'h0AA,   1,1,0, 11'h007, 9'h055,  0, 9'h000, 9'h0AA, 9'h000, 9'h1C3));
        vecs.push_back(mk("coll_rr",   1,0,0, 11'h007, 9'h000,   1,0,0, 11'h007, 9'h000,  1, 9'h0AA, 9'h0AA, 9'h0AA, 9'h0AA));
        vecs.push_back(mk("coll_wr",   1,1,0, 11'h007, 9'h1BB,   1,0,0, 11'h007, 9'h000,  1, 9'h0AA, 9'h1BB, 9'h0AA, 9'h0AA));
        vecs.push_back(mk("coll_after",0,0,0, 11'h000, 9'h000,   1,0,0, 11'h007, 9'h000,  1, 9'h1BB, 9'h1BB, 9'h0AA, 9'h0AA));
        vecs.push_back(mk("wrap_wr",   1,1,0, 11'h7FF, 9'h1E1,   1,0,0, 11'h7FF, 9'h000,  1, 9'h000, 9'h1E1, 9'h000, 9'h0AA));
        vecs.push_back(mk("wrap_rd",   1,0,0, 11'h000, 9'h000,   1,0,0, 11'h7FF, 9'h000,  1, 9'h1E1, 9'h000, 9'h000, 9'h000));
        vecs.push_back(mk("b_wfirst",  0,0,0, 11'h000, 9'h000,   1,1,0, 11'h020, 9'h077,  1, 9'h077, 9'h000, 9'h000, 9'h000));
        vecs.push_back(mk("ena_off",   0,1,0, 11'h020, 9'h1FF,   0,0,0, 11'h000, 9'h000,  1, 9'h077, 9'h000, 9'h000, 9'h000));
        vecs.push_back(mk("ena_off_rd",1,0,0, 11'h020, 9'h000,   0,0,0, 11'h000, 9'h000,  1, 9'h077, 9'h077, 9'h077, 9'h077));

        foreach (vecs[i]) apply(vecs[i]);

        // Burst: port B fills 0..63 with data = address, port A reads back 63..0.
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            ENA = 1'b0; WEA = 1'b0;
            ENB = 1'b1; WEB = 1'b1; SSRB = 1'b0;
            ADDRB = 11'(i); {DIPB, DIB} = 9'(i);
        end
        for (int i = 63; i >= 0; i--) begin
            @(negedge clock);
            ENB = 1'b0; WEB = 1'b0;
            ENA = 1'b1; WEA = 1'b0; SSRA = 1'b0; ADDRA = 11'(i);
            @(posedge clock);
            #1;
            check_a_all($sformatf("burst_%0d", i), 9'(i), 9'(i), 9'(i));
        end

        // Reset asserted between edges takes effect immediately.
        @(negedge clock);
        drive_idle();
        #2 reset_n = 1'b0;
        #1;
        check_a_all("rst_mid", 9'h1AB, 9'h1AB, 9'h1AB);
        check("rst_mid.b", {dopb[0], dob[0]}, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
